custom_mux_arbiter: RTL and testbench
=====================================

CUSTOM_MUX_ARBITER -- requirements
Module: custom_mux_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 operation request; level, held until gnt0.
REQ-005 op0  input  2  requester 0 select: 00 A, 01 B, 10 A+B, 11 A-B.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands.
REQ-007 req1, op1, a1, b1  input  1/2/WIDTH/WIDTH  requester 1 equivalents.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-009 result  output  WIDTH  selected/computed value, held until the next valid.
REQ-010 carry  output  1  carry-out for 10, borrow for 11, 0 for 00/01.
REQ-011 valid  output  1  one-cycle pulse; result/carry/owner are valid.
REQ-012 owner  output  1  requester index for the current result.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 FSM states: IDLE, EXEC and DONE; all outputs registered.
REQ-015 IDLE, no request: remain in IDLE.
REQ-016 IDLE, one or more requests at edge N:
  - latch winner op/a/b
  - drive its gnt high for cycle N+1 only
  - go to EXEC
REQ-017 EXEC, at the next edge:
  - result <= f(op,a,b), truncated to WIDTH
  - assert carry and owner
  - valid <= 1
  - go to DONE
REQ-018 DONE, at the next edge: valid <= 0; go to IDLE; result/carry/owner hold.
REQ-019 Latency:
  - request sampled at edge N; gnt visible in cycle N+1
  - valid visible in cycle N+2
  - next request sampled at edge N+3
  - one operation per 3 cycles maximum
REQ-020 A+B: result = (A+B) mod 2^WIDTH; carry = bit WIDTH of the unsigned sum.
REQ-021 A-B: result = (A-B) mod 2^WIDTH; carry = 1 if A<B (unsigned).
REQ-022 Arbitration:
  - round-robin using a last-owner register
  - only one request present: it wins
  - both requests present: the requester that is not last-owner wins
  - last-owner updates on each grant
REQ-023 Requests, op changes and operand changes during EXEC/DONE are ignored; the latched operands are used.
REQ-024 A request dropped before its gnt is not served; no state is retained for it.
REQ-025 Only one gnt is asserted in any cycle; gnt0 and gnt1 are never high together.

Reset
REQ-026 With rst high at an edge, the following are 0 from the next cycle:
  - state = IDLE
  - gnt0, gnt1, valid, busy, result, carry, owner
  - last-owner = 1, so requester 0 wins the first tie
REQ-027 rst has priority over all transitions; in-flight operations are abandoned and produce no valid.
REQ-028 Requests present in the cycle rst deasserts are sampled at the following edge.

Verification (WIDTH=8)
REQ-029 After reset, req0=1, op0=10, a0=1, b0=2 -> gnt0 pulses in cycle +1; valid in cycle +2 with result=0x03, carry=0, owner=0.
REQ-030 req1=1, op1=11, a1=0x01, b1=0x02 -> result=0xFF, carry=1, owner=1.
REQ-031 op0=10, a0=0xFF, b0=0x01 -> result=0x00, carry=1; op0=00/01 with a0=0x5A, b0=0xA5 -> 0x5A/0xA5, carry=0.
REQ-032 Both requests held from reset:
  - grants alternate 0,1,0,1, each 3 cycles apart
  - owner follows the same order
  - gnt0 and gnt1 never high in the same cycle
REQ-033 rst asserted in EXEC -> next cycle: all outputs 0 and busy=0; no valid for that operation; the next tie is granted to requester 0.
REQ-034 a0 changed to 0x10 during EXEC (latched a0=0x01, b0=0x02, op0=10) -> result=0x03.

Source files
------------

// File: rtl/custom_mux_arbiter.sv
// custom_mux_arbiter: round-robin arbiter between two requesters feeding a
// select/add/subtract unit; one operation per IDLE->EXEC->DONE pass.
module custom_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             valid,
    output logic             owner,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t r_state, w_next;
    logic r_last, r_gnt0, r_gnt1, r_valid, r_owner, r_busy, r_carry;
    logic [1:0] r_op;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic w_take, w_win;
    logic [WIDTH:0] w_res;
    // On a tie the requester that did not win last time takes the grant
    assign w_take = (r_state == IDLE) && (req0 || req1);
    assign w_win  = (req0 && req1) ? !r_last : req1;
    always_comb begin
        w_next = r_state == EXEC ? DONE : w_take ? EXEC : IDLE;
        // Bit WIDTH of the zero-extended difference is the unsigned borrow
        w_res  = r_op == 2'b00 ? {1'b0, r_a} :
                 r_op == 2'b01 ? {1'b0, r_b} :
                 r_op == 2'b10 ? {1'b0, r_a} + {1'b0, r_b} :
                                 {1'b0, r_a} - {1'b0, r_b};
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_gnt0  <= w_take && !w_win;
            r_gnt1  <= w_take && w_win;
            r_valid <= r_state == EXEC;
            r_busy  <= w_next != IDLE;
            if (w_take) begin
                r_op   <= w_win ? op1 : op0;
                r_a    <= w_win ? a1 : a0;
                r_b    <= w_win ? b1 : b0;
                r_last <= w_win;
            end
            if (r_state == EXEC) begin
                r_result <= w_res[WIDTH-1:0];
                r_carry  <= w_res[WIDTH];
                r_owner  <= r_last;
            end
        end
    end
    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign valid  = r_valid;
    assign busy   = r_busy;
    assign result = r_result;
    assign carry  = r_carry;
    assign owner  = r_owner;
endmodule

// File: tb/tb_custom_mux_arbiter.sv
// tb_custom_mux_arbiter: directed literal cases plus randomized traffic checked
// every cycle against an event-scheduling model of the arbiter.
module tb_custom_mux_arbiter;
    localparam int W = 8;
    localparam int M = 1 << W;
    logic clk = 1'b0, rst = 1'b1;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic gnt0, gnt1, carry, valid, owner, busy;
    logic [W-1:0] result;
    int n_chk = 0, n_fail = 0;
    int k = 0;
    custom_mux_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .result(result), .carry(carry),
        .valid(valid), .owner(owner), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, k);
        end
    endtask
    // Reference: a grant at edge g schedules gnt in the following cycle, the
    // result one edge later, and blocks sampling until edge g+3.
    bit m_ok = 0, pend = 0, m_last = 1;
    int next_ok = 0, v_edge = 0;
    bit e_g0, e_g1, e_v, e_busy, e_c, e_own, p_c, p_own;
    int e_res, p_res;
    always @(posedge clk) begin
        int a, b, w;
        int op;
        k++;
        if (rst) begin
            {e_g0, e_g1, e_v, e_busy, e_c, e_own} = '0;
            e_res = 0; pend = 0; m_last = 1; next_ok = k + 1; m_ok = 1;
        end else begin
            e_g0 = 0; e_g1 = 0; e_v = 0;
            if (pend && k == v_edge) begin
                e_v = 1; e_res = p_res; e_c = p_c; e_own = p_own; pend = 0;
            end else if (k >= next_ok && (req0 || req1)) begin
                w  = (req0 && req1) ? int'(!m_last) : int'(req1);
                op = w ? int'(op1) : int'(op0);
                a  = w ? int'(a1) : int'(a0);
                b  = w ? int'(b1) : int'(b0);
                case (op)
                    0: begin p_res = a; p_c = 0; end
                    1: begin p_res = b; p_c = 0; end
                    2: begin p_res = (a + b) % M; p_c = (a + b) >= M; end
                    default: begin p_res = (a - b + M) % M; p_c = a < b; end
                endcase
                if (w != 0) e_g1 = 1; else e_g0 = 1;
                m_last = w != 0; p_own = w != 0; pend = 1;
                v_edge = k + 1; next_ok = k + 3;
            end
            e_busy = k < next_ok - 1;
        end
    end
    always @(negedge clk) begin
        if (m_ok) begin
            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("gnt_exclusive", gnt0 & gnt1, 0);
            chk("valid", valid, e_v);
            chk("busy", busy, e_busy);
            chk("result", result, e_res);
            chk("carry", carry, e_c);
            chk("owner", owner, e_own);
        end
    end
    task automatic run_op(input bit r, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] xr, input bit xc, input bit chg);
        int t;
        @(negedge clk);
        if (r) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
        else   begin req0 = 1; op0 = op; a0 = a; b0 = b; end
        t = 0;
        do begin @(negedge clk); t++; end while (!(r ? gnt1 : gnt0) && t < 10);
        chk("lit_gnt", r ? gnt1 : gnt0, 1);
        chk("lit_gnt_latency", t, 1);
        req0 = 0; req1 = 0;
        if (chg) a0 = 8'h10;
        t = 0;
        do begin @(negedge clk); t++; end while (!valid && t < 5);
        chk("lit_valid_latency", t, 1);
        chk("lit_result", result, xr);
        chk("lit_carry", carry, xc);
        chk("lit_owner", owner, r);
    endtask
    initial begin
        int who[$], when[$];
        repeat (2) @(negedge clk);
        rst = 0;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_result", result, 0);
        chk("lit_rst_owner", owner, 0);
        run_op(0, 2'b10, 8'h01, 8'h02, 8'h03, 0, 0);
        run_op(1, 2'b11, 8'h01, 8'h02, 8'hFF, 1, 0);
        run_op(0, 2'b10, 8'hFF, 8'h01, 8'h00, 1, 0);
        run_op(0, 2'b00, 8'h5A, 8'hA5, 8'h5A, 0, 0);
        run_op(0, 2'b01, 8'h5A, 8'hA5, 8'hA5, 0, 0);
        run_op(0, 2'b10, 8'h01, 8'h02, 8'h03, 0, 1);
        // Both requesters held from reset: strict alternation every 3 cycles
        @(negedge clk);
        rst = 1; req0 = 1; req1 = 1; op0 = 2'b00; op1 = 2'b01;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin who.push_back(gnt1); when.push_back(i); end
        end
        req0 = 0; req1 = 0;
        chk("lit_rr_count", who.size() >= 4, 1);
        for (int i = 0; i < 4 && i < who.size(); i++) begin
            chk("lit_rr_order", who[i], i % 2);
            if (i > 0) chk("lit_rr_spacing", when[i] - when[i-1], 3);
        end
        // Reset during EXEC abandons the operation and restores the tie-break
        repeat (3) @(negedge clk);
        req0 = 1; op0 = 2'b10; a0 = 8'h01; b0 = 8'h02;
        @(negedge clk);
        chk("lit_abort_gnt0", gnt0, 1);
        req0 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("lit_abort_busy", busy, 0);
        chk("lit_abort_valid", valid, 0);
        chk("lit_abort_result", result, 0);
        req0 = 1; req1 = 1;
        @(negedge clk);
        chk("lit_tie_gnt0", gnt0, 1);
        chk("lit_tie_gnt1", gnt1, 0);
        req0 = 0; req1 = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst  = $urandom_range(0, 149) == 0;
            req0 = req0 ? !((gnt0 && $urandom_range(0, 1) == 1) || $urandom_range(0, 15) == 0)
                        : $urandom_range(0, 2) == 0;
            req1 = req1 ? !((gnt1 && $urandom_range(0, 1) == 1) || $urandom_range(0, 15) == 0)
                        : $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 1) == 1) begin
                op0 = 2'($urandom); op1 = 2'($urandom);
                a0 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
                b0 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
                a1 = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
                b1 = $urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom);
            end
        end
        rst = 0; req0 = 0; req1 = 0;
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", k);
        $fatal(1, "timeout");
    end
endmodule
